// File: rtl/eth_pkt_lib.sv
// Shared stream-interface properties and width helpers for eth_pkt_if blocks.
package eth_pkt_lib;

   typedef struct packed {
      logic [15:0] data_width;
   } if_properties_t;

   localparam if_properties_t DEFAULT_PROPERTIES = '{data_width: 16'd64};

   function automatic int get_if_data_width(input if_properties_t p);
      return int'(p.data_width);
   endfunction

   // mod counts valid bytes of the eop word; 0 encodes a full word
   function automatic int get_if_mod_width(input if_properties_t p);
      int bytes;
      bytes = get_if_data_width(p) / 8;
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/eth_pkt_byte_merge.sv
// Overlays a run of field bytes onto a data word; byte lane 0 is the word MSB.
module eth_pkt_byte_merge #(
   parameter int FIELD_BYTES = 6,
   parameter int D_WIDTH     = 64,
   parameter int LANE_W      = 3,
   parameter int CNT_W       = 4
) (
   input  logic [D_WIDTH-1:0]       word,
   input  logic [FIELD_BYTES*8-1:0] value,
   input  logic [LANE_W-1:0]        start_lane,
   input  logic [CNT_W-1:0]         byte_cnt,
   input  logic [LANE_W-1:0]        value_off,
   output logic [D_WIDTH-1:0]       merged,
   output logic [D_WIDTH/8-1:0]     lane_mask
);

   localparam int unsigned D_BYTES = D_WIDTH / 8;

   always_comb begin
      int unsigned idx;
      merged    = word;
      lane_mask = '0;
      idx       = 0;
      for (int unsigned l = 0; l < D_BYTES; l++) begin
         if (l >= 32'(start_lane) && l < 32'(start_lane) + 32'(byte_cnt)) begin
            idx = 32'(value_off) + l - 32'(start_lane);
            if (idx < FIELD_BYTES) begin
               merged[D_WIDTH-1-8*l -: 8] = value[8*(FIELD_BYTES-1-idx) +: 8];
               lane_mask[l]               = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/eth_pkt_field_locator.sv
// Locates a fixed-length field by byte offset within eth_pkt_if packets and
// presents the patched word to the downstream replace stage.
import eth_pkt_lib::*;

module eth_pkt_field_locator #(
   parameter if_properties_t IF_PROPERTIES = DEFAULT_PROPERTIES,
   parameter int D_WIDTH      = get_if_data_width(IF_PROPERTIES),
   parameter int MOD_WIDTH    = get_if_mod_width(IF_PROPERTIES),
   parameter int FIELD_BYTES  = 6,
   parameter int OFFSET_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     field_en_i,
   input  logic [OFFSET_WIDTH-1:0]  field_offset_i,
   input  logic [FIELD_BYTES*8-1:0] field_value_i,
   input  logic [D_WIDTH-1:0]       pkt_data_i,
   input  logic                     pkt_sop_i,
   input  logic                     pkt_eop_i,
   input  logic [MOD_WIDTH-1:0]     pkt_mod_i,
   input  logic                     pkt_val_i,
   input  logic                     pkt_ready_i,
   output logic [D_WIDTH-1:0]       next_data_o,
   output logic                     next_data_replace_en_o,
   output logic                     patched_o,
   output logic                     short_pkt_o
);

   localparam int unsigned D_BYTES = D_WIDTH / 8;
   localparam int LANE_W = (D_BYTES > 1) ? $clog2(D_BYTES) : 1;
   localparam int CNT_W  = $clog2(D_BYTES + 1);

   typedef enum logic [1:0] {IDLE, SEEK, SECOND, DONE} state_t;

   state_t                   state, next_state, eval_state;
   logic [OFFSET_WIDTH-1:0]  word_cnt;
   logic                     cfg_en;
   logic [OFFSET_WIDTH-1:0]  cfg_off;
   logic [FIELD_BYTES*8-1:0] cfg_val;

   logic                     sop_beat, accept;
   logic [OFFSET_WIDTH-1:0]  eff_off;
   logic [FIELD_BYTES*8-1:0] eff_val;
   int unsigned              word_idx, start_word, lane;
   int unsigned              m_lane, m_cnt, m_voff, last_lane;
   logic                     split, hit, final_part, in_bounds, complete;
   logic [D_WIDTH-1:0]       merged;
   logic [D_BYTES-1:0]       lane_mask;

   eth_pkt_byte_merge #(
      .FIELD_BYTES (FIELD_BYTES),
      .D_WIDTH     (D_WIDTH),
      .LANE_W      (LANE_W),
      .CNT_W       (CNT_W)
   ) u_merge (
      .word       (pkt_data_i),
      .value      (eff_val),
      .start_lane (LANE_W'(m_lane)),
      .byte_cnt   (CNT_W'(m_cnt)),
      .value_off  (LANE_W'(m_voff)),
      .merged     (merged),
      .lane_mask  (lane_mask)
   );

   // A sop beat is evaluated as if the state had already been re-armed from the live config
   always_comb begin
      sop_beat   = pkt_val_i & pkt_sop_i;
      accept     = pkt_val_i & pkt_ready_i;
      eff_off    = sop_beat ? field_offset_i : cfg_off;
      eff_val    = sop_beat ? field_value_i : cfg_val;
      eval_state = state;
      if (sop_beat) eval_state = field_en_i ? SEEK : DONE;
      word_idx   = sop_beat ? 0 : 32'(word_cnt);
      start_word = 32'(eff_off) / D_BYTES;
      lane       = 32'(eff_off) % D_BYTES;
      split      = (lane + FIELD_BYTES) > D_BYTES;

      hit        = 1'b0;
      final_part = 1'b0;
      m_lane     = 0;
      m_cnt      = 0;
      m_voff     = 0;
      last_lane  = 0;
      case (eval_state)
         SEEK: begin
            if (word_idx == start_word) begin
               hit        = 1'b1;
               m_lane     = lane;
               m_cnt      = split ? D_BYTES - lane : FIELD_BYTES;
               final_part = !split;
               last_lane  = lane + FIELD_BYTES - 1;
            end
         end
         SECOND: begin
            hit        = 1'b1;
            m_voff     = D_BYTES - lane;
            m_cnt      = FIELD_BYTES - m_voff;
            final_part = 1'b1;
            last_lane  = m_cnt - 1;
         end
         default: ;
      endcase

      in_bounds = !pkt_eop_i || (pkt_mod_i == '0) || (last_lane < 32'(pkt_mod_i));
      complete  = final_part & in_bounds;

      next_data_o            = merged;
      next_data_replace_en_o = pkt_val_i & (|lane_mask);

      next_state = state;
      if (accept) begin
         if (pkt_eop_i)               next_state = IDLE;
         else if (complete)           next_state = DONE;
         else if (hit && !final_part) next_state = SECOND;
         else                         next_state = eval_state;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         word_cnt    <= '0;
         cfg_en      <= 1'b0;
         cfg_off     <= '0;
         cfg_val     <= '0;
         patched_o   <= 1'b0;
         short_pkt_o <= 1'b0;
      end else begin
         state       <= next_state;
         patched_o   <= accept & complete;
         short_pkt_o <= accept & pkt_eop_i & !complete &
                        ((eval_state == SEEK) || (eval_state == SECOND));
         if (accept) begin
            if (pkt_sop_i) begin
               word_cnt <= OFFSET_WIDTH'(1);
               cfg_en   <= field_en_i;
               cfg_off  <= field_offset_i;
               cfg_val  <= field_value_i;
            end else if (word_cnt != '1) begin
               word_cnt <= word_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/eth_pkt_field_locator.md
# eth_pkt_field_locator

Tracks byte position inside packets on an `eth_pkt_if` stream and overlays a configurable fixed-length field at a configurable byte offset. It sits directly upstream of `eth_pkt_if_replace`, driving its `next_data_i` / `next_data_replace_en_i`. It taps the same beats that the replace stage forwards, so the patched field lands on the correct words, including fields that straddle two words.

## Interface
- `IF_PROPERTIES`, `eth_pkt_lib::DEFAULT_PROPERTIES`, stream properties.
- `D_WIDTH`, `get_if_data_width(IF_PROPERTIES)`, data width; `D_BYTES = D_WIDTH/8`.
- `MOD_WIDTH`, `get_if_mod_width(IF_PROPERTIES)`, `mod` width.
- `FIELD_BYTES`, 6, field length; must satisfy 1 ≤ `FIELD_BYTES` ≤ `D_BYTES`.
- `OFFSET_WIDTH`, 16, byte-offset width.

Ports (`name  dir  width  meaning`):
- `clk_i  in  1`: single clock.
- `rst_i  in  1`: synchronous, active-high reset.
- `field_en_i  in  1`: enable patching; sampled on the sop beat.
- `field_offset_i  in  OFFSET_WIDTH`: byte offset of the field from packet byte 0; sampled on sop.
- `field_value_i  in  FIELD_BYTES*8`: field value, first byte in the MSBs; sampled on sop.
- `pkt_data_i, pkt_sop_i, pkt_eop_i, pkt_mod_i, pkt_val_i, pkt_ready_i  in`: tap of the stream.
- `next_data_o  out  D_WIDTH`: current word with field bytes merged.
- `next_data_replace_en_o  out  1`: current word carries field bytes.
- `patched_o  out  1`: one-cycle pulse; the field was completely written.
- `short_pkt_o  out  1`: one-cycle pulse; eop arrived before the field was complete.

## Operation
- Byte order: packet byte 0 of a word is `data[D_WIDTH-1 -: 8]`. `mod` is the count of valid bytes in the eop word, with 0 meaning all `D_BYTES` are valid.
- A beat is accepted when `pkt_val_i & pkt_ready_i`.
- Word index is 0 on the sop beat, otherwise the registered `word_cnt`. The counter increments per accepted beat and saturates at its maximum.
- The field covers bytes `[off, off+FIELD_BYTES-1]`. Start word is `off / D_BYTES` and start lane is `off % D_BYTES`.
- The field spans two words when `lane + FIELD_BYTES > D_BYTES`.
- FSM states:
  - `IDLE`: no packet open. Non-sop beats are ignored, so replace_en stays 0.
  - `SEEK`: packet open, field not yet reached.
  - `SECOND`: first part written, remainder pending in the next word.
  - `DONE`: field complete, or disabled, for the rest of the packet.
- Transitions, all on accepted beats:
  - sop beat (from any state) latches config. It goes to `SEEK` if enabled, otherwise `DONE`, then evaluates the sop word itself.
  - In `SEEK`, a word matching the start word writes the first part. It then goes to `SECOND` if split, else `DONE`.
  - In `SECOND`, the next word writes the remainder and goes to `DONE`.
  - An eop beat returns to `IDLE`.
- Outputs are combinational from the tap and registered state. For the sop beat they use the live config inputs; afterwards they use the latched copy.
- `next_data_replace_en_o` requires `pkt_val_i` and does not depend on `pkt_ready_i`. The output holds stable through stalls.
- Only field bytes are replaced; other lanes pass `pkt_data_i` unchanged.
- Completion requires the last field byte to lie within the valid bytes of its word. If the eop `mod` excludes it, bytes are still overlaid but `short_pkt_o` fires instead of `patched_o`.
- `short_pkt_o` fires on eop when the field is enabled and incomplete. This includes the case where the offset is beyond the packet end.
- sop while in `SEEK`/`SECOND` (missing eop): restart cleanly with no pulse.

## Timing
- Data path latency is 0 cycles (combinational).
- `patched_o` / `short_pkt_o` are registered and pulse in the cycle after the completing or eop beat.
- Reset values: state `IDLE`, `word_cnt` 0, latched config 0, `patched_o` 0, `short_pkt_o` 0. `next_data_replace_en_o` is 0 and `next_data_o` equals `pkt_data_i` until a sop beat is accepted.
- Reset mid-packet: remaining beats up to the next sop are not patched and produce no pulses.

## Structure
- Add `get_if_mod_width()` to `eth_pkt_lib` if it is absent. The FSM state enum stays local.
- Sub-module `eth_pkt_byte_merge`: combinational. Inputs are a word, a value, a start lane, a byte count and a value byte offset; the output is the merged word plus a lane mask. Two instances are not needed: a single instance with the lane and offset muxed by state suffices.

## Test plan
- D_WIDTH=64, off=12, value=0x112233445566, 3-word packet → word1 lanes 4–7 = 11 22 33 44, word2 lanes 0–1 = 55 66; `patched_o` pulses once after word2.
- off=0, single-word packet (sop&eop, mod=0) → lanes 0–5 replaced and `patched_o` pulses; with mod=4 → `short_pkt_o` pulses instead.
- off=100 on a 4-word packet → replace_en stays 0 and `short_pkt_o` pulses after eop.
- `pkt_ready_i` low for 3 cycles during word1 of the split case → outputs hold stable, `word_cnt` does not advance, and the result is identical to the unstalled run.
- sop mid-packet, and `rst_i` asserted mid-packet followed by non-sop beats → new packet patched correctly; the beats after reset are unpatched and produce no pulses.
- `field_en_i`=0 → `next_data_o` equals `pkt_data_i` and replace_en is 0 throughout.
